// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60 timing defaults, derived active offsets and RGB222 colours
package vga_pkg;

  localparam int VGA_H_SYNC  = 96;
  localparam int VGA_H_BACK  = 48;
  localparam int VGA_H_DISP  = 640;
  localparam int VGA_H_FRONT = 16;
  localparam int VGA_H_TOTAL = VGA_H_SYNC + VGA_H_BACK + VGA_H_DISP + VGA_H_FRONT;
  localparam int VGA_H_ACT   = VGA_H_SYNC + VGA_H_BACK;

  localparam int VGA_V_SYNC  = 2;
  localparam int VGA_V_BACK  = 33;
  localparam int VGA_V_DISP  = 480;
  localparam int VGA_V_FRONT = 10;
  localparam int VGA_V_TOTAL = VGA_V_SYNC + VGA_V_BACK + VGA_V_DISP + VGA_V_FRONT;
  localparam int VGA_V_ACT   = VGA_V_SYNC + VGA_V_BACK;

  localparam logic VGA_HS_POL = 1'b0;
  localparam logic VGA_VS_POL = 1'b0;

  localparam logic [5:0] WHITE   = 6'h3F;
  localparam logic [5:0] YELLOW  = 6'h3C;
  localparam logic [5:0] CYAN    = 6'h0F;
  localparam logic [5:0] GREEN   = 6'h0C;
  localparam logic [5:0] MAGENTA = 6'h33;
  localparam logic [5:0] RED     = 6'h30;
  localparam logic [5:0] BLUE    = 6'h03;
  localparam logic [5:0] BLACK   = 6'h00;

  // Colour bars left to right, white down to black.
  function automatic logic [5:0] bar_colour(input logic [2:0] idx);
    logic [5:0] c;
    case (idx)
      3'd0:    c = WHITE;
      3'd1:    c = YELLOW;
      3'd2:    c = CYAN;
      3'd3:    c = GREEN;
      3'd4:    c = MAGENTA;
      3'd5:    c = RED;
      3'd6:    c = BLUE;
      default: c = BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// rtl/vga_axis_cnt.sv - wrapping 10-bit counter with enable and terminal-count flag
module vga_axis_cnt #(
  parameter int CNT_MAX = 800
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  output logic [9:0] o_cnt,
  output logic       o_term
);

  localparam logic [9:0] C_LAST = 10'(CNT_MAX - 1);

  logic [9:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= 10'd0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == C_LAST) ? 10'd0 : r_cnt + 10'd1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_term = (r_cnt == C_LAST);

endmodule

// File: rtl/vga_driver.sv
// rtl/vga_driver.sv - VGA timing generator with one-cycle-early pixel request and gated RGB222 output
// VGA_TEST_PATTERN_EN adds test_mode, which replaces pixel_data with eight colour bars.
module vga_driver
  import vga_pkg::*;
#(
  parameter int   H_SYNC  = VGA_H_SYNC,
  parameter int   H_BACK  = VGA_H_BACK,
  parameter int   H_DISP  = VGA_H_DISP,
  parameter int   H_FRONT = VGA_H_FRONT,
  parameter int   V_SYNC  = VGA_V_SYNC,
  parameter int   V_BACK  = VGA_V_BACK,
  parameter int   V_DISP  = VGA_V_DISP,
  parameter int   V_FRONT = VGA_V_FRONT,
  parameter logic HS_POL  = VGA_HS_POL,
  parameter logic VS_POL  = VGA_VS_POL
) (
  input  logic       pixel_clk,
  input  logic       sys_rst_n,
  input  logic [5:0] pixel_data,
  output logic [9:0] pixel_xpos,
  output logic [9:0] pixel_ypos,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_de,
  output logic [5:0] vga_rgb,
  output logic       frame_start
`ifdef VGA_TEST_PATTERN_EN
  ,
  input  logic       test_mode
`endif
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int H_ACT   = H_SYNC + H_BACK;
  localparam int V_ACT   = V_SYNC + V_BACK;

  localparam logic [9:0] C_H_SYNC   = 10'(H_SYNC);
  localparam logic [9:0] C_H_ACT    = 10'(H_ACT);
  localparam logic [9:0] C_H_END    = 10'(H_ACT + H_DISP);
  localparam logic [9:0] C_H_REQ_LO = 10'(H_ACT - 1);
  localparam logic [9:0] C_H_REQ_HI = 10'(H_ACT + H_DISP - 2);
  localparam logic [9:0] C_V_SYNC   = 10'(V_SYNC);
  localparam logic [9:0] C_V_ACT    = 10'(V_ACT);
  localparam logic [9:0] C_V_END    = 10'(V_ACT + V_DISP);

  logic [9:0] w_h_cnt;
  logic [9:0] w_v_cnt;
  logic       w_h_term;
  logic       w_v_term;
  logic       w_h_disp;
  logic       w_v_disp;
  logic       w_req;
  logic [5:0] w_rgb;
  logic       r_frame_start;

  vga_axis_cnt #(.CNT_MAX(H_TOTAL)) u_h_cnt (
    .i_clk   (pixel_clk),
    .i_rst_n (sys_rst_n),
    .i_en    (1'b1),
    .o_cnt   (w_h_cnt),
    .o_term  (w_h_term)
  );

  vga_axis_cnt #(.CNT_MAX(V_TOTAL)) u_v_cnt (
    .i_clk   (pixel_clk),
    .i_rst_n (sys_rst_n),
    .i_en    (w_h_term),
    .o_cnt   (w_v_cnt),
    .o_term  (w_v_term)
  );

  // Set only by a real frame wrap, so the restart after reset produces no pulse.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_h_term & w_v_term;
    end
  end

  assign vga_hs   = (w_h_cnt < C_H_SYNC) ? HS_POL : ~HS_POL;
  assign vga_vs   = (w_v_cnt < C_V_SYNC) ? VS_POL : ~VS_POL;
  assign w_h_disp = (w_h_cnt >= C_H_ACT) && (w_h_cnt < C_H_END);
  assign w_v_disp = (w_v_cnt >= C_V_ACT) && (w_v_cnt < C_V_END);
  assign vga_de   = w_h_disp & w_v_disp;

  // Request leads display by one pixel to cover the renderer's register stage.
  assign w_req      = (w_h_cnt >= C_H_REQ_LO) && (w_h_cnt <= C_H_REQ_HI) && w_v_disp;
  assign pixel_xpos = w_req ? (w_h_cnt - C_H_REQ_LO) : 10'd0;
  assign pixel_ypos = w_req ? (w_v_cnt - C_V_ACT) : 10'd0;

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [9:0] C_BAR_W = 10'(H_DISP / 8);
  logic [9:0] w_bar_x;
  logic [2:0] w_bar_idx;
  assign w_bar_x   = w_h_cnt - C_H_ACT;
  assign w_bar_idx = 3'(w_bar_x / C_BAR_W);
  assign w_rgb     = test_mode ? bar_colour(w_bar_idx) : pixel_data;
`else
  assign w_rgb = pixel_data;
`endif

  assign vga_rgb     = vga_de ? w_rgb : 6'd0;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_driver.sv
// tb/tb_vga_driver.sv - randomized check of vga_driver against a cycle-index timing model
// Drives a shrunk-timing instance through many frames and a default-timing instance through its first active lines.
module tb_vga_driver;

  localparam int S_HS = 16, S_HB = 8, S_HD = 128, S_HF = 8;
  localparam int S_VS = 2,  S_VB = 3, S_VD = 8,   S_VF = 2;
  localparam int S_HT = S_HS + S_HB + S_HD + S_HF;
  localparam int S_FRAME = S_HT * (S_VS + S_VB + S_VD + S_VF);
  localparam int D_HS = 96, D_HB = 48, D_HD = 640, D_HF = 16;
  localparam int D_VS = 2,  D_VB = 33, D_VD = 480, D_VF = 10;

  typedef struct {
    bit hs;
    bit vs;
    bit de;
    bit fs;
    int x;
    int y;
    int dx;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       test_mode = 1'b0;
  logic [5:0] pd_s = 6'd0, pd_d = 6'd0;
  logic       hs_s, vs_s, de_s, fs_s, hs_d, vs_d, de_d, fs_d;
  logic [9:0] x_s, y_s, x_d, y_d;
  logic [5:0] rgb_s, rgb_d;

  longint     t = 0;
  int         checks = 0;
  int         failures = 0;
  int         de_cnt_s = 0;
  bit         render_mode = 1'b0;
  logic [9:0] cap_x_s = 10'd0, cap_x_d = 10'd0;
  exp_t       prev_s, prev_d;

`ifdef VGA_TEST_PATTERN_EN
  logic [5:0] bars [8] = '{6'h3F, 6'h3C, 6'h0F, 6'h0C, 6'h33, 6'h30, 6'h03, 6'h00};
`endif

  always #5 clk = ~clk;

  vga_driver #(
    .H_SYNC(S_HS), .H_BACK(S_HB), .H_DISP(S_HD), .H_FRONT(S_HF),
    .V_SYNC(S_VS), .V_BACK(S_VB), .V_DISP(S_VD), .V_FRONT(S_VF),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) u_small (
    .pixel_clk   (clk),
    .sys_rst_n   (rst_n),
    .pixel_data  (pd_s),
    .pixel_xpos  (x_s),
    .pixel_ypos  (y_s),
    .vga_hs      (hs_s),
    .vga_vs      (vs_s),
    .vga_de      (de_s),
    .vga_rgb     (rgb_s),
    .frame_start (fs_s)
`ifdef VGA_TEST_PATTERN_EN
    ,
    .test_mode   (test_mode)
`endif
  );

  vga_driver u_std (
    .pixel_clk   (clk),
    .sys_rst_n   (rst_n),
    .pixel_data  (pd_d),
    .pixel_xpos  (x_d),
    .pixel_ypos  (y_d),
    .vga_hs      (hs_d),
    .vga_vs      (vs_d),
    .vga_de      (de_d),
    .vga_rgb     (rgb_d),
    .frame_start (fs_d)
`ifdef VGA_TEST_PATTERN_EN
    ,
    .test_mode   (test_mode)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0d", tag, act, exp, t);
    end
  endtask

  // Expected outputs for the state reached after tt rising edges since reset release.
  function automatic exp_t model(input longint tt, input int hsn, input int hbk, input int hds,
                                 input int hfp, input int vsn, input int vbk, input int vds,
                                 input int vfp);
    exp_t e;
    int   ht, vt, h, v, ha, va;
    bit   line_on;
    ht = hsn + hbk + hds + hfp;
    vt = vsn + vbk + vds + vfp;
    h  = int'(tt % ht);
    v  = int'((tt / ht) % vt);
    ha = hsn + hbk;
    va = vsn + vbk;
    line_on = (v >= va) && (v < va + vds);
    e.hs = (h >= hsn);
    e.vs = (v >= vsn);
    e.de = line_on && (h >= ha) && (h < ha + hds);
    e.dx = h - ha;
    e.fs = (tt > 0) && ((tt % (ht * vt)) == 0);
    if (line_on && (h >= ha - 1) && (h <= ha + hds - 2)) begin
      e.x = h - ha + 1;
      e.y = v - va;
    end else begin
      e.x = 0;
      e.y = 0;
    end
    return e;
  endfunction

  task automatic check_inst(input string nm, input exp_t e, input logic [5:0] pd_exp, input int hds,
                            input logic hs, input logic vs, input logic de, input logic [9:0] x,
                            input logic [9:0] y, input logic [5:0] rgb, input logic fs);
    logic [5:0] rgb_exp;
    rgb_exp = e.de ? pd_exp : 6'd0;
`ifdef VGA_TEST_PATTERN_EN
    if (e.de && test_mode) rgb_exp = bars[e.dx / (hds / 8)];
`endif
    check_val({nm, ".hs"},  32'(hs),  32'(e.hs));
    check_val({nm, ".vs"},  32'(vs),  32'(e.vs));
    check_val({nm, ".de"},  32'(de),  32'(e.de));
    check_val({nm, ".x"},   32'(x),   32'(e.x));
    check_val({nm, ".y"},   32'(y),   32'(e.y));
    check_val({nm, ".rgb"}, 32'(rgb), 32'(rgb_exp));
    check_val({nm, ".fs"},  32'(fs),  32'(e.fs));
  endtask

  task automatic check_reset_state();
    exp_t z;
    z = '{default: 0};
    check_inst("rst_small", z, 6'd0, S_HD, hs_s, vs_s, de_s, x_s, y_s, rgb_s, fs_s);
    check_inst("rst_std",   z, 6'd0, D_HD, hs_d, vs_d, de_d, x_d, y_d, rgb_d, fs_d);
  endtask

  task automatic hold_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      pd_s = 6'($urandom);
      pd_d = 6'($urandom);
      #1;
      check_reset_state();
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    pd_s = 6'd0;
    pd_d = 6'd0;
    #1;
    t = 0;
    de_cnt_s = 0;
    prev_s = model(0, S_HS, S_HB, S_HD, S_HF, S_VS, S_VB, S_VD, S_VF);
    prev_d = model(0, D_HS, D_HB, D_HD, D_HF, D_VS, D_VB, D_VD, D_VF);
    check_inst("small", prev_s, 6'd0, S_HD, hs_s, vs_s, de_s, x_s, y_s, rgb_s, fs_s);
    check_inst("std",   prev_d, 6'd0, D_HD, hs_d, vs_d, de_d, x_d, y_d, rgb_d, fs_d);
    cap_x_s = x_s;
    cap_x_d = x_d;
  endtask

  task automatic run_cycles(input int n);
    exp_t       e_s, e_d;
    logic [5:0] pe_s, pe_d;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      t++;
      if ((t % S_HT) == 0) begin
        render_mode = 1'($urandom_range(0, 1));
`ifdef VGA_TEST_PATTERN_EN
        test_mode = ($urandom_range(0, 2) == 0);
`endif
      end
      // Renderer mode: pixel_data is last cycle's request, as a registered renderer would return.
      if (render_mode) begin
        pd_s = cap_x_s[5:0];
        pd_d = cap_x_d[5:0];
        pe_s = 6'(prev_s.x);
        pe_d = 6'(prev_d.x);
      end else begin
        pd_s = 6'($urandom);
        pd_d = 6'($urandom);
        pe_s = pd_s;
        pe_d = pd_d;
      end
      #1;
      e_s = model(t, S_HS, S_HB, S_HD, S_HF, S_VS, S_VB, S_VD, S_VF);
      e_d = model(t, D_HS, D_HB, D_HD, D_HF, D_VS, D_VB, D_VD, D_VF);
      check_inst("small", e_s, pe_s, S_HD, hs_s, vs_s, de_s, x_s, y_s, rgb_s, fs_s);
      check_inst("std",   e_d, pe_d, D_HD, hs_d, vs_d, de_d, x_d, y_d, rgb_d, fs_d);
      if (de_s) de_cnt_s++;
      if (((t + 1) % S_FRAME) == 0) begin
        check_val("small.de_per_frame", 32'(de_cnt_s), 32'(S_HD * S_VD));
        de_cnt_s = 0;
      end
      cap_x_s = x_s;
      cap_x_d = x_d;
      prev_s  = e_s;
      prev_d  = e_d;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    #1;
    check_reset_state();
    hold_reset(3);
    release_reset();
    run_cycles(2 * S_FRAME + 10 * S_HT + 100);

    // Mid-frame async reset: outputs must return to reset values before the next edge.
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_state();
    hold_reset(3);
    release_reset();
    run_cycles(36 * 800 + 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
